// File: rtl/mac_poly_pipe.sv
// mac_poly_pipe: pipelined Horner evaluator, coefficient set travels with each sample.
// Define MAC_POLY_SAT_EN to clamp out-of-range results instead of wrapping them.
module mac_poly_pipe #(
    parameter int ORDER = 5,
    parameter int BC    = 16,
    parameter int BT    = 16,
    parameter int BY    = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [BT-1:0]           t_in,
    input  logic [(ORDER+1)*BC-1:0] c_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [BY-1:0]           y_out,
    output logic                    y_valid,
    input  logic                    y_ready
);
    localparam int G   = $clog2(ORDER + 1);
    localparam int BA  = BC + G;
    localparam int CW  = (ORDER + 1) * BC;
    localparam int NS  = 2 * ORDER;
    localparam int RSH = (BY < BC) ? BC - BY - 1 : 0;
    localparam logic [BA:0] RND = (BY < BC) ? ((BA+1)'(1) << RSH) : '0;

    logic          w_ce;
    logic [NS-1:0] r_v;
    logic          r_y_valid;
    logic [BY-1:0] r_y;

    assign w_ce     = ~r_y_valid | y_ready;
    assign in_ready = w_ce;
    assign y_valid  = r_y_valid;
    assign y_out    = r_y;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_v <= '0;
        end else if (w_ce) begin
            r_v <= {r_v[NS-2:0], in_valid};
        end
    end

    // Stage j: reg1 holds (acc*t)>>>BT, reg2 adds c(ORDER-1-j).
    for (genvar j = 0; j < ORDER; j++) begin : g_stg
        localparam int K = ORDER - 1 - j;

        logic signed [BA-1:0]  w_acc_in;
        logic [BT-1:0]         w_t_in;
        logic [CW-1:0]         w_c_in;
        logic signed [BA+BT:0] w_prod;
        logic signed [BA-1:0]  w_ck;
        logic                  w_unused;
        logic signed [BA-1:0]  r_p;
        logic [BT-1:0]         r_t1;
        logic [CW-1:0]         r_c1;
        logic signed [BA-1:0]  r_acc;
        logic [BT-1:0]         r_t2;
        logic [CW-1:0]         r_c2;

        if (j == 0) begin : g_head
            assign w_acc_in = {{G{c_in[CW-1]}}, c_in[CW-1 -: BC]};
            assign w_t_in   = t_in;
            assign w_c_in   = c_in;
        end else begin : g_body
            assign w_acc_in = g_stg[j-1].r_acc;
            assign w_t_in   = g_stg[j-1].r_t2;
            assign w_c_in   = g_stg[j-1].r_c2;
        end

        assign w_prod   = w_acc_in * $signed({1'b0, w_t_in});
        assign w_ck     = {{G{r_c1[K*BC+BC-1]}}, r_c1[K*BC +: BC]};
        assign w_unused = ^{w_prod[BA+BT], w_prod[BT-1:0], r_t2, r_c2};

        always_ff @(posedge clk) begin
            if (w_ce) begin
                r_p   <= w_prod[BT +: BA];
                r_t1  <= w_t_in;
                r_c1  <= w_c_in;
                r_acc <= w_ck + r_p;
                r_t2  <= r_t1;
                r_c2  <= r_c1;
            end
        end
    end

    logic signed [BA-1:0] w_acc;
    logic [BA:0]          w_r;
    logic                 w_ovf;
    logic [BY-1:0]        w_y;
    logic                 w_unused_o;

    assign w_acc = g_stg[ORDER-1].r_acc;
    assign w_r   = {w_acc[BA-1], w_acc} + RND;
    // Result fits BC bits only if all bits above the BC sign bit agree.
    assign w_ovf = (w_r[BA:BC-1] != '0) && (w_r[BA:BC-1] != '1);

`ifdef MAC_POLY_SAT_EN
    assign w_y = !w_ovf ? w_r[BC-1 -: BY] :
                 w_r[BA] ? {1'b1, {(BY-1){1'b0}}} :
                           {1'b0, {(BY-1){1'b1}}};
`else
    assign w_y = w_r[BC-1 -: BY];
`endif

    assign w_unused_o = ^{w_r, w_ovf};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_y_valid <= 1'b0;
            r_y       <= '0;
        end else if (w_ce) begin
            r_y_valid <= r_v[NS-1];
            if (r_v[NS-1]) begin
                r_y <= w_y;
            end
        end
    end
endmodule
